// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, FSM state encoding and word/data width defaults.
// No logic of its own; the master, slave and RAM models all agree on these values.
// A change to an opcode or width here changes the on-wire protocol for every block.
package spi_pkg;

  localparam int WORD_W = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEL       = 3'd1;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd2;
  localparam logic [2:0] ST_TURN      = 3'd3;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  // Only a read-data command keeps SS_n low to collect a byte from the slave.
  function automatic logic op_has_readback(input logic [1:0] op);
    case (op)
      CMD_RD_DATA:                          return 1'b1;
      CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: return 1'b0;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first PISO for MOSI, SIPO for MISO, and a down-counting bit counter with done flag.
// MOSI is registered: load presents the MSB on the next cycle; each out_en cycle advances one bit.
// No backpressure; the controlling FSM decides when to load, shift, sample and reload the count.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int WORD_W = spi_pkg::WORD_W,
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int CNT_W  = spi_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              out_en,
  input  logic              in_en,
  input  logic              miso,
  input  logic              cnt_load,
  input  logic [CNT_W-1:0]  cnt_val,
  output logic              mosi,
  output logic [DATA_W-1:0] din_next,
  output logic              done
);

  logic [WORD_W-1:0] sh_out;
  logic [DATA_W-1:0] din;
  logic [CNT_W-1:0]  cnt;

  assign din_next = {din[DATA_W-2:0], miso};
  assign done     = (cnt == '0);

  // Transmit side: load the word, then clock out MSB first; mosi idles at 0 when not shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_out <= '0;
      mosi   <= 1'b0;
    end else if (load) begin
      sh_out <= load_word;
      mosi   <= load_word[WORD_W-1];
    end else if (out_en) begin
      sh_out <= {sh_out[WORD_W-2:0], 1'b0};
      mosi   <= sh_out[WORD_W-1];
    end else begin
      mosi   <= 1'b0;
    end
  end

  // Receive side: shift MISO in MSB first while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din <= '0;
    end else if (in_en) begin
      din <= din_next;
    end
  end

  // Bit counter: reload on state entry, count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_load) begin
      cnt <= cnt_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises 10-bit host commands on MOSI and captures read-data bytes from MISO.
// Latency: SS_n falls on the accept edge; 11-cycle write frames, 21-cycle read-data frames.
// Backpressure: req_ready drops for the whole frame and returns only once the idle gap is met.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int WORD_W     = spi_pkg::WORD_W,
  parameter int DATA_W     = spi_pkg::DATA_W,
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_word,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             readback;
  logic             accept;
  logic             done;
  logic             out_en;
  logic             in_en;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_val;
  logic [DATA_W-1:0] din_next;
  logic             last_sample;

  // Ready in the last gap cycle too, so back-to-back frames are separated by exactly IDLE_GAP.
  assign req_ready   = (state == ST_IDLE) || ((state == ST_GAP) && done);
  assign accept      = req_valid && req_ready;
  assign busy        = (state != ST_IDLE);
  assign out_en      = (state == ST_SEL) || ((state == ST_SHIFT_OUT) && !done);
  assign in_en       = (state == ST_SHIFT_IN);
  assign last_sample = (state == ST_SHIFT_IN) && done;

  // Next-state logic; the bit counter is reloaded on every state entry.
  always_comb begin
    state_nx = state;
    cnt_ld   = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEL;
          cnt_ld   = 1'b1;
        end
      end
      ST_SEL: begin
        state_nx = ST_SHIFT_OUT;
        cnt_ld   = 1'b1;
        cnt_val  = CNT_W'(WORD_W - 1);
      end
      ST_SHIFT_OUT: begin
        if (done) begin
          cnt_ld = 1'b1;
          if (readback) begin
            state_nx = ST_TURN;
            cnt_val  = CNT_W'(TURNAROUND - 1);
          end else begin
            state_nx = ST_GAP;
            cnt_val  = CNT_W'(IDLE_GAP - 1);
          end
        end
      end
      ST_TURN: begin
        if (done) begin
          state_nx = ST_SHIFT_IN;
          cnt_ld   = 1'b1;
          cnt_val  = CNT_W'(DATA_W - 1);
        end
      end
      ST_SHIFT_IN: begin
        if (done) begin
          state_nx = ST_GAP;
          cnt_ld   = 1'b1;
          cnt_val  = CNT_W'(IDLE_GAP - 1);
        end
      end
      ST_GAP: begin
        if (accept) begin
          state_nx = ST_SEL;
          cnt_ld   = 1'b1;
        end else if (done) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register and latched frame type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      readback <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        readback <= op_has_readback(req_word[WORD_W-1 -: 2]);
      end
    end
  end

  // Slave select is registered from the next state, so it tracks the frame with no comb path out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n <= 1'b1;
    end else begin
      ss_n <= (state_nx == ST_IDLE) || (state_nx == ST_GAP);
    end
  end

  // Response: pulse valid and capture the full byte on the edge that takes the 8th sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= last_sample;
      if (last_sample) begin
        rsp_data <= din_next;
      end
    end
  end

  spi_shift_reg #(
    .WORD_W (WORD_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_word (req_word),
    .out_en    (out_en),
    .in_en     (in_en),
    .miso      (miso),
    .cnt_load  (cnt_ld),
    .cnt_val   (cnt_val),
    .mosi      (mosi),
    .din_next  (din_next),
    .done      (done)
  );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default turnaround, and turnaround 4).
// Instance A talks to a behavioural slave with a 256-byte RAM; instance B returns a fixed 0x5A.
// Table-driven single frames plus hand-written reset, back-to-back and gap sequences.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [9:0] req_word  = '0;
  logic       sel = 1'b0;

  logic       req_valid_a, req_ready_a, rsp_valid_a, busy_a, ss_n_a, mosi_a;
  logic       miso_a = 1'b1;
  logic [7:0] rsp_data_a;
  logic       req_valid_b, req_ready_b, rsp_valid_b, busy_b, ss_n_b, mosi_b;
  logic       miso_b = 1'b1;
  logic [7:0] rsp_data_b;

  logic       m_ready, m_busy, m_ss_n, m_mosi, m_rsp_valid;
  logic [7:0] m_rsp_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;
  assign m_ready     = sel ? req_ready_b : req_ready_a;
  assign m_busy      = sel ? busy_b      : busy_a;
  assign m_ss_n      = sel ? ss_n_b      : ss_n_a;
  assign m_mosi      = sel ? mosi_b      : mosi_a;
  assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign m_rsp_data  = sel ? rsp_data_b  : rsp_data_a;

  spi_master_ctrl dut_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_a),
    .req_ready (req_ready_a),
    .req_word  (req_word),
    .rsp_valid (rsp_valid_a),
    .rsp_data  (rsp_data_a),
    .busy      (busy_a),
    .ss_n      (ss_n_a),
    .mosi      (mosi_a),
    .miso      (miso_a)
  );

  spi_master_ctrl #(.TURNAROUND(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid_b),
    .req_ready (req_ready_b),
    .req_word  (req_word),
    .rsp_valid (rsp_valid_b),
    .rsp_data  (rsp_data_b),
    .busy      (busy_b),
    .ss_n      (ss_n_b),
    .mosi      (mosi_b),
    .miso      (miso_b)
  );

  // Slave + RAM model for instance A. Low-cycle index 0 is the select bit, 1..10 the word,
  // 11..12 turnaround, 13..20 the returned byte. MISO idles high to expose mistimed sampling.
  int         ka = 0;
  logic [9:0] wa = '0;
  logic [7:0] addr_a = '0;
  logic [7:0] rbyte_a = '0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [9:0] seen_q [$];

  always @(negedge clk) begin
    if (ss_n_a) begin
      ka = 0;
      miso_a = 1'b1;
    end else begin
      if (ka >= 1 && ka <= 10) wa = {wa[8:0], mosi_a};
      if (ka == 10) begin
        seen_q.push_back(wa);
        case (wa[9:8])
          2'b00, 2'b10: addr_a = wa[7:0];
          2'b01:        mem[addr_a] = wa[7:0];
          default:      rbyte_a = mem[addr_a];
        endcase
      end
      if (ka >= 13 && ka <= 20) miso_a = rbyte_a[20-ka];
      else                      miso_a = 1'b1;
      ka++;
    end
  end

  // Fixed-byte slave for instance B: turnaround 4, so the byte occupies low cycles 15..22.
  int         kb = 0;
  logic [7:0] byte_b = 8'h5A;

  always @(negedge clk) begin
    if (ss_n_b) begin
      kb = 0;
      miso_b = 1'b1;
    end else begin
      if (kb >= 15 && kb <= 22) miso_b = byte_b[22-kb];
      else                      miso_b = 1'b1;
      kb++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one word on the selected instance and measure the resulting frame.
  task automatic run_frame(input logic [9:0] w, output logic ok, output int low_n,
                           output int busy_n, output logic [10:0] mosi_v,
                           output int rsp_n, output logic [7:0] rsp_d);
    @(negedge clk);
    req_word  = w;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_word  = ~w;
    low_n = 0; busy_n = 0; rsp_n = 0; mosi_v = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!m_busy) break;
      busy_n++;
      if (!m_ss_n) begin
        if (low_n < 11) mosi_v[10-low_n] = m_mosi;
        low_n++;
      end
      if (m_rsp_valid) rsp_n++;
    end
    rsp_d = m_rsp_data;
  endtask

  typedef struct {
    logic       sel;
    logic [9:0] word;
    int         low;
    int         busy;
    int         rsp;
    logic [7:0] data;
  } vec_t;

  vec_t        vecs [9];
  logic        ok;
  int          low_n, busy_n, rsp_n, cnt, falls, run, idx;
  logic [10:0] mosi_v;
  logic [10:0] exp_m;
  logic [7:0]  rsp_d;
  logic        prev;
  logic [9:0]  q [3];

  initial begin
    vecs[0] = '{1'b0, 10'b00_1010_0101, 11, 12, 0, 8'h00};
    vecs[1] = '{1'b0, 10'h010, 11, 12, 0, 8'h00};
    vecs[2] = '{1'b0, 10'h1C3, 11, 12, 0, 8'h00};
    vecs[3] = '{1'b0, 10'h210, 11, 12, 0, 8'h00};
    vecs[4] = '{1'b0, 10'h300, 21, 22, 1, 8'hC3};
    vecs[5] = '{1'b0, 10'h17E, 11, 12, 0, 8'hC3};
    vecs[6] = '{1'b0, 10'h3FF, 21, 22, 1, 8'h7E};
    vecs[7] = '{1'b1, 10'h300, 23, 24, 1, 8'h5A};
    vecs[8] = '{1'b1, 10'h2AA, 11, 12, 0, 8'h5A};

    // Reset values, checked while reset is held and again after release.
    repeat (3) @(negedge clk);
    check("rst_ss_n", ss_n_a, 1);
    check("rst_busy", busy_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ss_n", ss_n_a, 1);
    check("idle_mosi", mosi_a, 0);
    check("idle_ready", req_ready_a, 1);
    check("idle_rsp_valid", rsp_valid_a, 0);
    check("idle_rsp_data", rsp_data_a, 0);
    check("idle_busy", busy_a, 0);
    check("idle_ready_b", req_ready_b, 1);

    // Reset in the middle of a read-data frame.
    req_word  = 10'h300;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_frame_active", ss_n_a, 0);
    rst = 1'b1;
    #1;
    check("midrst_ss_n", ss_n_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_mosi", mosi_a, 0);
    cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid_a || !ss_n_a) cnt++;
    end
    check("midrst_no_rsp_or_frame", cnt, 0);
    check("midrst_ready_after", req_ready_a, 1);

    // Table of single frames.
    for (int i = 0; i < 9; i++) begin
      sel = vecs[i].sel;
      run_frame(vecs[i].word, ok, low_n, busy_n, mosi_v, rsp_n, rsp_d);
      exp_m = {vecs[i].word[9], vecs[i].word};
      check($sformatf("v%0d_accept", i), ok, 1);
      check($sformatf("v%0d_ss_low_cycles", i), low_n, vecs[i].low);
      check($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].busy);
      check($sformatf("v%0d_mosi_bits", i), mosi_v, exp_m);
      check($sformatf("v%0d_rsp_pulses", i), rsp_n, vecs[i].rsp);
      check($sformatf("v%0d_rsp_data", i), rsp_d, vecs[i].data);
    end
    sel = 1'b0;

    // Back-to-back: req_valid held with three queued words.
    q[0] = 10'h010; q[1] = 10'h1C3; q[2] = 10'h022;
    seen_q.delete();
    @(negedge clk);
    idx = 0; falls = 0; run = 0; prev = 1'b1;
    req_word  = q[0];
    req_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (c > 0) @(negedge clk);
      if (!ss_n_a) begin
        if (prev) begin
          falls++;
          if (falls > 1) check($sformatf("b2b_gap_before_frame%0d", falls), run, 1);
        end
        run = 0;
      end else begin
        run++;
      end
      prev = ss_n_a;
      if (idx == 3 && !busy_a) break;
      if (req_valid && req_ready_a) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) req_word = q[idx];
        else         req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepted", idx, 3);
    check("b2b_frames", falls, 3);
    check("b2b_words_seen", seen_q.size(), 3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
      check($sformatf("b2b_word%0d", i), seen_q[i], q[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
